// File: rtl/rfid_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rfid_seq_ctrl
//  Description : Reader-side command sequencer. Drives one inventory-and-access
//                round (SORT -> QUERY -> ACK -> READ [-> WRITE]) through the
//                reader emulator's TX encoder, supervises every tag reply with
//                a timeout and a bounded retry count, and owns the sticky
//                stage-complete LEDs.
//  Ports       : clk_50m, rst_p        - clock, synchronous active-high reset
//                start, abort          - board-level round controls
//                cmd_req/cmd_code/cmd_ack - command handshake to the TX encoder
//                rpl_valid/rpl_crc_ok  - tag reply strobe from the RX decoder
//                busy/done/fail/err_stage/retry_cnt - round status
//                led_sort..led_done    - sticky stage-complete indicators
//  Config      : SEQ_WRITE_STAGE_EN - when defined, WRITE follows READ and
//                led_write is functional; otherwise the round ends after READ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rfid_seq_ctrl #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int GAP_CYC     = 100,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk_50m,
    input  logic       rst_p,
    input  logic       start,
    input  logic       abort,
    output logic       cmd_req,
    output logic [2:0] cmd_code,
    input  logic       cmd_ack,
    input  logic       rpl_valid,
    input  logic       rpl_crc_ok,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [2:0] err_stage,
    output logic [1:0] retry_cnt,
    output logic       led_sort,
    output logic       led_query,
    output logic       led_ack,
    output logic       led_read,
    output logic       led_write,
    output logic       led_done
);

    localparam int         c_CNT_W      = 17;
    localparam logic [2:0] c_CODE_NONE  = 3'd0;
    localparam logic [2:0] c_CODE_SORT  = 3'd1;
    localparam logic [2:0] c_CODE_QUERY = 3'd2;
    localparam logic [2:0] c_CODE_ACK   = 3'd3;
    localparam logic [2:0] c_CODE_READ  = 3'd4;
    localparam logic [2:0] c_CODE_WRITE = 3'd5;
    localparam logic [2:0] c_CODE_ABORT = 3'd7;

`ifdef SEQ_WRITE_STAGE_EN
    localparam logic [2:0] c_LAST_STAGE = c_CODE_WRITE;
`else
    localparam logic [2:0] c_LAST_STAGE = c_CODE_READ;
`endif

    // Terminal counts: the counter starts at 0 on the cycle after the ack, so
    // the event fires on the edge where it has reached N-1.
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST     = c_CNT_W'(GAP_CYC - 1);
    localparam logic [1:0]         c_MAX_RETRY    = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    state_t              r_state;
    logic [2:0]          r_stage;
    logic [c_CNT_W-1:0]  r_wait_cnt;
    // bit order: {done, write, read, ack, query, sort}
    logic [5:0]          r_leds;

    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                w_timeout;
    logic [2:0]          w_next_stage;
    logic [5:0]          w_stage_led;

    always_comb begin
        w_cnt_inc    = (r_wait_cnt == {c_CNT_W{1'b1}}) ? r_wait_cnt : r_wait_cnt + 1'b1;
        w_timeout    = (r_wait_cnt == c_TIMEOUT_LAST);
        w_next_stage = r_stage + 3'd1;
        w_stage_led  = 6'b000000;
        case (r_stage)
            c_CODE_SORT:  w_stage_led = 6'b000001;
            c_CODE_QUERY: w_stage_led = 6'b000010;
            c_CODE_ACK:   w_stage_led = 6'b000100;
            c_CODE_READ:  w_stage_led = 6'b001000;
            c_CODE_WRITE: w_stage_led = 6'b010000;
            default:      w_stage_led = 6'b000000;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst_p) begin
            r_state    <= ST_IDLE;
            r_stage    <= c_CODE_NONE;
            r_wait_cnt <= '0;
            r_leds     <= '0;
            cmd_req    <= 1'b0;
            cmd_code   <= c_CODE_NONE;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            err_stage  <= c_CODE_NONE;
            retry_cnt  <= 2'd0;
        end else if (abort && busy) begin
            // busy is high exactly in ISSUE, GAP and WAIT; abort beats every
            // other event in those states.
            r_state   <= ST_FAIL;
            cmd_req   <= 1'b0;
            cmd_code  <= c_CODE_NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b1;
            err_stage <= c_CODE_ABORT;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        r_state   <= ST_ISSUE;
                        r_stage   <= c_CODE_SORT;
                        r_leds    <= '0;
                        cmd_req   <= 1'b1;
                        cmd_code  <= c_CODE_SORT;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        err_stage <= c_CODE_NONE;
                        retry_cnt <= 2'd0;
                    end
                end

                ST_ISSUE: begin
                    if (cmd_ack) begin
                        cmd_req    <= 1'b0;
                        cmd_code   <= c_CODE_NONE;
                        r_wait_cnt <= '0;
                        r_state    <= (r_stage == c_CODE_SORT) ? ST_GAP : ST_WAIT;
                    end
                end

                ST_GAP: begin
                    // SORT has no tag reply; only a guard interval precedes QUERY.
                    if (r_wait_cnt == c_GAP_LAST) begin
                        r_leds[0] <= 1'b1;
                        r_stage   <= c_CODE_QUERY;
                        retry_cnt <= 2'd0;
                        cmd_req   <= 1'b1;
                        cmd_code  <= c_CODE_QUERY;
                        r_state   <= ST_ISSUE;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                    end
                end

                ST_WAIT: begin
                    // A good reply is tested first so it wins over a timeout
                    // expiring in the same cycle.
                    if (rpl_valid && rpl_crc_ok) begin
                        retry_cnt <= 2'd0;
                        if (r_stage == c_LAST_STAGE) begin
                            r_leds  <= r_leds | w_stage_led | 6'b100000;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_leds   <= r_leds | w_stage_led;
                            r_stage  <= w_next_stage;
                            cmd_req  <= 1'b1;
                            cmd_code <= w_next_stage;
                            r_state  <= ST_ISSUE;
                        end
                    end else if (rpl_valid || w_timeout) begin
                        if (retry_cnt < c_MAX_RETRY) begin
                            retry_cnt <= retry_cnt + 2'd1;
                            cmd_req   <= 1'b1;
                            cmd_code  <= r_stage;
                            r_state   <= ST_ISSUE;
                        end else begin
                            err_stage <= r_stage;
                            busy      <= 1'b0;
                            fail      <= 1'b1;
                            r_state   <= ST_FAIL;
                        end
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign led_sort  = r_leds[0];
    assign led_query = r_leds[1];
    assign led_ack   = r_leds[2];
    assign led_read  = r_leds[3];
    assign led_write = r_leds[4];
    assign led_done  = r_leds[5];

endmodule
`default_nettype wire

// File: tb/tb_rfid_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rfid_seq_ctrl
//  Description : Self-checking bench for rfid_seq_ctrl. Stimulus pushes the
//                expected command codes into a queue; a monitor pops and
//                compares one entry on every rising cmd_req.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rfid_seq_ctrl;

    localparam int T = 300;
    localparam int G = 10;

`ifdef SEQ_WRITE_STAGE_EN
    localparam int         N_STAGES = 5;
    localparam logic [5:0] LED_ALL  = 6'b111111;
`else
    localparam int         N_STAGES = 4;
    localparam logic [5:0] LED_ALL  = 6'b101111;
`endif

    logic       clk_50m = 1'b0;
    logic       rst_p = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cmd_ack = 1'b0;
    logic       rpl_valid = 1'b0;
    logic       rpl_crc_ok = 1'b0;
    logic       cmd_req, busy, done, fail;
    logic [2:0] cmd_code, err_stage;
    logic [1:0] retry_cnt;
    logic       led_sort, led_query, led_ack, led_read, led_write, led_done;

    rfid_seq_ctrl #(.TIMEOUT_CYC(T), .GAP_CYC(G), .MAX_RETRY(3)) dut (
        .clk_50m(clk_50m), .rst_p(rst_p), .start(start), .abort(abort),
        .cmd_req(cmd_req), .cmd_code(cmd_code), .cmd_ack(cmd_ack),
        .rpl_valid(rpl_valid), .rpl_crc_ok(rpl_crc_ok),
        .busy(busy), .done(done), .fail(fail), .err_stage(err_stage),
        .retry_cnt(retry_cnt),
        .led_sort(led_sort), .led_query(led_query), .led_ack(led_ack),
        .led_read(led_read), .led_write(led_write), .led_done(led_done)
    );

    always #10 clk_50m = ~clk_50m;

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    int         checks = 0;
    int         failures = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;
    logic       prev_req = 1'b0;

    wire [5:0]  leds    = {led_done, led_write, led_read, led_ack, led_query, led_sort};
    wire [17:0] all_out = {cmd_req, cmd_code, busy, done, fail, err_stage, retry_cnt, leds};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one expected code per new command request.
    always @(negedge clk_50m) begin
        if (cmd_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req: got code %0d expected no request", cmd_code);
            end else begin
                mon_exp = exp_q.pop_front();
                check("cmd_code", 32'(cmd_code), 32'(mon_exp));
            end
        end
        prev_req = cmd_req;
    end

    // All tasks are entered and left on a falling edge.
    task automatic wait_req(output int rcyc);
        int n = 0;
        while (!cmd_req && n < 2000) begin
            @(negedge clk_50m);
            n++;
        end
        if (!cmd_req) begin
            checks++;
            failures++;
            $display("FAIL req_wait: cmd_req=0 expected 1 within 2000 cycles");
            rcyc = -1;
        end else begin
            rcyc = cyc;
        end
    endtask

    // Ack two cycles after the request is seen; returns the edge it is sampled on.
    task automatic do_ack(output int mcyc);
        repeat (2) @(negedge clk_50m);
        cmd_ack = 1'b1;
        mcyc = cyc + 1;
        @(negedge clk_50m);
        cmd_ack = 1'b0;
    endtask

    // Called on the falling edge right after the ack edge M; reply sampled at M+d.
    task automatic do_reply(input int d, input logic ok);
        repeat (d - 1) @(negedge clk_50m);
        rpl_valid  = 1'b1;
        rpl_crc_ok = ok;
        @(negedge clk_50m);
        rpl_valid  = 1'b0;
        rpl_crc_ok = 1'b0;
    endtask

    task automatic serve(input logic ok, input int d);
        int r, m;
        wait_req(r);
        do_ack(m);
        do_reply(d, ok);
    endtask

    task automatic serve_sort();
        int r, m, q;
        wait_req(r);
        do_ack(m);
        wait_req(q);
        check("gap_spacing", 32'(q - m), 32'(G));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_50m);
        start = 1'b0;
    endtask

    task automatic push_round();
        for (int c = 1; c <= N_STAGES; c++) exp_q.push_back(3'(c));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int r, m, prev_r;

        // Reset
        repeat (3) @(negedge clk_50m);
        check("reset_outputs", 32'(all_out), 32'd0);
        rst_p = 1'b0;
        @(negedge clk_50m);

        // Nominal round
        push_round();
        pulse_start();
        check("start_busy", 32'({busy, cmd_req}), 32'b11);
        serve_sort();
        for (int s = 2; s <= N_STAGES; s++) serve(1'b1, 200);
        check("nominal_done_fail_busy", 32'({done, fail, busy}), 32'b100);
        check("nominal_retry", 32'(retry_cnt), 32'd0);
        check("nominal_leds", 32'(leds), 32'(LED_ALL));

        // CRC retry on QUERY (restart from DONE)
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd2);
        for (int c = 2; c <= N_STAGES; c++) exp_q.push_back(3'(c));
        pulse_start();
        check("restart_leds_clear", 32'({leds, done}), 32'd0);
        serve_sort();
        serve(1'b0, 200);
        check("crc_retry_1", 32'(retry_cnt), 32'd1);
        serve(1'b0, 200);
        check("crc_retry_2", 32'(retry_cnt), 32'd2);
        serve(1'b1, 200);
        check("crc_retry_reset", 32'(retry_cnt), 32'd0);
        for (int s = 3; s <= N_STAGES; s++) serve(1'b1, 200);
        check("crc_done", 32'({done, fail}), 32'b10);

        // Timeout exhaustion on READ
        for (int c = 1; c <= 4; c++) exp_q.push_back(3'(c));
        repeat (3) exp_q.push_back(3'd4);
        pulse_start();
        serve_sort();
        serve(1'b1, 200);
        serve(1'b1, 200);
        prev_r = 0;
        for (int i = 0; i < 4; i++) begin
            wait_req(r);
            if (i > 0) check("read_retry_spacing", 32'(r - prev_r), 32'(T + 3));
            prev_r = r;
            do_ack(m);
        end
        repeat (T - 1) @(negedge clk_50m);
        check("timeout_not_yet", 32'(fail), 32'd0);
        @(negedge clk_50m);
        check("timeout_fail", 32'({fail, done, busy}), 32'b100);
        check("timeout_err_stage", 32'(err_stage), 32'd4);
        check("timeout_leds", 32'({led_read, led_ack}), 32'b01);

        // Reply on the final timeout cycle, start while busy, abort
        for (int c = 1; c <= 3; c++) exp_q.push_back(3'(c));
        pulse_start();
        check("restart_from_fail", 32'({fail, err_stage}), 32'd0);
        serve_sort();
        wait_req(r);
        do_ack(m);
        do_reply(T, 1'b1);
        check("collision_no_retry", 32'({retry_cnt, cmd_req}), 32'b001);
        wait_req(r);
        do_ack(m);
        @(negedge clk_50m);
        pulse_start();
        check("start_while_busy", 32'({busy, cmd_req, led_query}), 32'b101);
        repeat (5) @(negedge clk_50m);
        abort = 1'b1;
        @(negedge clk_50m);
        abort = 1'b0;
        check("abort_status", 32'({fail, busy, cmd_req, done}), 32'b1000);
        check("abort_err_stage", 32'(err_stage), 32'd7);

        // Reset mid-round
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        pulse_start();
        serve_sort();
        wait_req(r);
        do_ack(m);
        repeat (20) @(negedge clk_50m);
        check("pre_reset_state", 32'({led_sort, busy}), 32'b11);
        rst_p = 1'b1;
        @(negedge clk_50m);
        rst_p = 1'b0;
        check("midround_reset", 32'(all_out), 32'd0);
        repeat (20) @(negedge clk_50m);
        check("reset_stays_idle", 32'(all_out), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
